// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg -- shared constants and types for the programmable clock divider.
//
// Contents:
//   DW_DEFAULT       default width of a channel's divide value
//   NCH_DEFAULT      default number of divider channels
//   DIV_RST_DEFAULT  divide value every channel holds out of reset (clk/10)
//   clk_div_state_t  layout of one channel's state at the default width
//                    (counter, active divide, shadow divide, pending, output)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DW_DEFAULT      = 8;
    localparam int NCH_DEFAULT     = 4;
    localparam int DIV_RST_DEFAULT = 4;

    // Channel state at the default width. Channels with a different DW keep
    // the same fields at their own width.
    typedef struct packed {
        logic [DW_DEFAULT-1:0] cnt;    // cycles elapsed in current half-period
        logic [DW_DEFAULT-1:0] div_q;  // divide value in use
        logic [DW_DEFAULT-1:0] div_s;  // last written divide value
        logic                  pend;   // div_s not yet copied into div_q
        logic                  out;    // divided clock level
    } clk_div_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan -- one channel of the programmable clock divider.
//
// out_o toggles every (div_q + 1) enabled cycles, giving a 2*(D+1) period at
// 50% duty. A written divide value is parked in the shadow register and only
// taken over at a half-period boundary (or at once while the channel is
// disabled), so a running half-period is never cut short.
//
// Optional feature (macro PROG_CLK_DIV_SYNC_EN): sync_i restarts an enabled
// channel from phase zero and applies any pending value.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous reset, active low
//   en_i    in   run enable
//   wr_i    in   write strobe for this channel (already decoded)
//   div_i   in   divide value to write
//   sync_i  in   phase restart (only with PROG_CLK_DIV_SYNC_EN)
//   out_o   out  divided clock, registered
//   tick_o  out  one-cycle pulse in the cycle after out_o toggled
//   pend_o  out  a written value is waiting to be applied
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int DIV_RST = DIV_RST_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          wr_i,
    input  logic [DW-1:0] div_i,
`ifdef PROG_CLK_DIV_SYNC_EN
    input  logic          sync_i,
`endif
    output logic          out_o,
    output logic          tick_o,
    output logic          pend_o
);

    localparam logic [DW-1:0] DIV_INIT = DW'(DIV_RST);

    logic [DW-1:0] cnt_q,  cnt_d;
    logic [DW-1:0] div_q,  div_d;
    logic [DW-1:0] divs_q, divs_d;
    logic          pend_q, pend_d;
    logic          out_q,  out_d;
    logic          tick_q, tick_d;

    logic terminal;
    logic apply;

    assign terminal = (cnt_q == div_q);
    // A write in the same cycle wins over an older pending value: only the
    // newest value ever reaches div_q, and it waits for the next boundary.
    assign apply    = pend_q && !wr_i;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        divs_d = divs_q;
        pend_d = pend_q;
        out_d  = out_q;
        tick_d = 1'b0;

        if (!en_i) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (apply) begin
                div_d  = divs_q;
                pend_d = 1'b0;
            end
`ifdef PROG_CLK_DIV_SYNC_EN
        end else if (sync_i) begin
            // Restart beats the terminal toggle of the same cycle.
            cnt_d = '0;
            out_d = 1'b0;
            if (apply) begin
                div_d  = divs_q;
                pend_d = 1'b0;
            end
`endif
        end else if (terminal) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = 1'b1;
            if (apply) begin
                div_d  = divs_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + DW'(1);
        end

        if (wr_i) begin
            divs_d = div_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            div_q  <= DIV_INIT;
            divs_q <= DIV_INIT;
            pend_q <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            divs_q <= divs_d;
            pend_q <= pend_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign out_o  = out_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/prog_clk_div.sv
// -----------------------------------------------------------------------------
// prog_clk_div -- NCH independent programmable clock dividers.
//
// Each channel produces out_clk with period 2*(D+1) clk cycles. Divide values
// are written one channel at a time through cfg_we/cfg_ch/cfg_div; a channel
// index of NCH or above matches no channel and is dropped.
//
// Optional feature (macro PROG_CLK_DIV_SYNC_EN): adds input sync_all which
// restarts every enabled channel from phase zero in the same cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous reset, active low
//   en       in   [NCH]  per-channel run enable
//   cfg_we   in   one-cycle write strobe
//   cfg_ch   in   [CW]   target channel of write
//   cfg_div  in   [DW]   new divide value
//   sync_all in   phase-align all channels (PROG_CLK_DIV_SYNC_EN only)
//   out_clk  out  [NCH]  divided clocks
//   tick     out  [NCH]  pulse in the cycle after out_clk toggled
//   pend     out  [NCH]  written value waiting to be applied
// -----------------------------------------------------------------------------
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter  int NCH     = NCH_DEFAULT,
    parameter  int DW      = DW_DEFAULT,
    parameter  int DIV_RST = DIV_RST_DEFAULT,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_div,
`ifdef PROG_CLK_DIV_SYNC_EN
    input  logic           sync_all,
`endif
    output logic [NCH-1:0] out_clk,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    logic [NCH-1:0] wr;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [CW-1:0] IDX = CW'(i);

        // Indices >= NCH equal no IDX, so out-of-range writes fall away here.
        assign wr[i] = cfg_we && (cfg_ch == IDX);

        clk_div_chan #(
            .DW      (DW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en_i   (en[i]),
            .wr_i   (wr[i]),
            .div_i  (cfg_div),
`ifdef PROG_CLK_DIV_SYNC_EN
            .sync_i (sync_all),
`endif
            .out_o  (out_clk[i]),
            .tick_o (tick[i]),
            .pend_o (pend[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_div -- self-checking bench for prog_clk_div.
//
// Two instances share stimulus: A with four channels, B with three, so a write
// to channel 3 lands in A and must be dropped by B. A reference model tracks,
// per channel, the cycles remaining in the current half-period and the queued
// divide value; outputs of both instances are compared against it every cycle.
// Define PROG_CLK_DIV_SYNC_EN to cover sync_all.
// -----------------------------------------------------------------------------
module tb_prog_clk_div;

    localparam int DW = 8;

    logic       clk;
    logic       reset;
    logic [3:0] en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       sync_all;
    logic [3:0] out_a, tick_a, pend_a;
    logic [2:0] out_b, tick_b, pend_b;

    int checks = 0;
    int errors = 0;

    prog_clk_div #(.NCH(4), .DW(DW), .DIV_RST(4)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
`ifdef PROG_CLK_DIV_SYNC_EN
        .sync_all(sync_all),
`endif
        .out_clk (out_a),
        .tick    (tick_a),
        .pend    (pend_a)
    );

    prog_clk_div #(.NCH(3), .DW(DW), .DIV_RST(4)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .en      (en[2:0]),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
`ifdef PROG_CLK_DIV_SYNC_EN
        .sync_all(sync_all),
`endif
        .out_clk (out_b),
        .tick    (tick_b),
        .pend    (pend_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // rem: cycles still to run in the current half (a half lasts D+1 cycles).
    int m_rem  [2][4];
    int m_dact [2][4];
    int m_dnew [2][4];
    bit m_pend [2][4];
    bit m_lvl  [2][4];
    bit m_tick [2][4];
    int nch [2] = '{4, 3};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 4; c++) begin
                    m_dact[i][c] = 4; m_dnew[i][c] = 4; m_pend[i][c] = 0;
                    m_lvl[i][c] = 0;  m_tick[i][c] = 0; m_rem[i][c] = 5;
                end
        end else begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < nch[i]; c++) begin
                    bit wr, restart;
                    wr = cfg_we && (int'(cfg_ch) < nch[i]) && (int'(cfg_ch) == c);
                    restart = !en[c];
`ifdef PROG_CLK_DIV_SYNC_EN
                    restart = restart || sync_all;
`endif
                    m_tick[i][c] = 0;
                    if (restart) begin
                        m_lvl[i][c] = 0;
                        if (m_pend[i][c] && !wr) begin m_dact[i][c] = m_dnew[i][c]; m_pend[i][c] = 0; end
                        m_rem[i][c] = m_dact[i][c] + 1;
                    end else if (m_rem[i][c] == 1) begin
                        m_lvl[i][c]  = !m_lvl[i][c];
                        m_tick[i][c] = 1;
                        if (m_pend[i][c] && !wr) begin m_dact[i][c] = m_dnew[i][c]; m_pend[i][c] = 0; end
                        m_rem[i][c] = m_dact[i][c] + 1;
                    end else begin
                        m_rem[i][c] = m_rem[i][c] - 1;
                    end
                    if (wr) begin m_dnew[i][c] = int'(cfg_div); m_pend[i][c] = 1; end
                end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, both instances, all outputs.
    always @(negedge clk) begin
        logic [3:0] eo, et, ep;
        for (int c = 0; c < 4; c++) begin
            eo[c] = m_lvl[0][c]; et[c] = m_tick[0][c]; ep[c] = m_pend[0][c];
        end
        chk("A.out_clk", {28'd0, out_a}, {28'd0, eo});
        chk("A.tick",    {28'd0, tick_a}, {28'd0, et});
        chk("A.pend",    {28'd0, pend_a}, {28'd0, ep});
        for (int c = 0; c < 3; c++) begin
            eo[c] = m_lvl[1][c]; et[c] = m_tick[1][c]; ep[c] = m_pend[1][c];
        end
        chk("B.out_clk", {29'd0, out_b}, {29'd0, eo[2:0]});
        chk("B.tick",    {29'd0, tick_b}, {29'd0, et[2:0]});
        chk("B.pend",    {29'd0, pend_b}, {29'd0, ep[2:0]});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 8'(d);
        step();
        cfg_we  = 1'b0;
    endtask

    // Cycles until tick on channel ch of A; a timeout counts as a failure.
    task automatic wait_tick(input int ch, input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_a[ch] && n < maxc);
        if (!tick_a[ch]) begin
            checks++; errors++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles", ch, maxc);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; sync_all = 1'b0;
        repeat (3) step();
        chk("rst out_clk", {28'd0, out_a}, 32'd0);
        chk("rst pend",    {28'd0, pend_a}, 32'd0);

        // Reset defaults: D=4 -> 5-cycle halves.
        en = 4'b0001;
        reset = 1'b1;
        wait_tick(0, 20, n); chk("rst first half", n, 5);
        chk("rst out high", {31'd0, out_a[0]}, 1);
        wait_tick(0, 20, n); chk("rst second half", n, 5);
        chk("idle chans low", {29'd0, out_a[3:1]}, 0);

        // Mid-period reprogram to D=1.
        repeat (2) step();
        write(0, 1);
        chk("reprog pend set", {31'd0, pend_a[0]}, 1);
        wait_tick(0, 20, n); chk("reprog half kept", n, 2);
        chk("reprog pend clr", {31'd0, pend_a[0]}, 0);
        wait_tick(0, 20, n); chk("reprog new half", n, 2);

        // Coincident write on the terminal cycle: D=3 running, write 7.
        write(0, 3);
        wait_tick(0, 20, n);
        wait_tick(0, 20, n); chk("D3 half", n, 4);
        repeat (3) step();
        write(0, 7);
        chk("coinc tick", {31'd0, tick_a[0]}, 1);
        chk("coinc pend", {31'd0, pend_a[0]}, 1);
        wait_tick(0, 20, n); chk("coinc old D", n, 4);
        wait_tick(0, 20, n); chk("coinc new D", n, 8);

        // Limits: D=0 on ch1, D=255 on ch2.
        write(1, 0);
        step();
        en[1] = 1'b1;
        wait_tick(1, 10, n); chk("D0 first", n, 1);
        for (int k = 0; k < 4; k++) begin
            logic prev;
            prev = out_a[1];
            step();
            chk("D0 toggle", {31'd0, out_a[1]}, {31'd0, ~prev});
        end
        write(2, 255);
        step();
        en[2] = 1'b1;
        wait_tick(2, 300, n); chk("D255 first", n, 256);
        wait_tick(2, 300, n); chk("D255 half", n, 256);

        // Out-of-range channel on the 3-channel instance.
        write(3, 9);
        chk("oor B pend", {29'd0, pend_b}, 0);
        chk("oor A pend", {31'd0, pend_a[3]}, 1);

        // Disable mid-period applies the pending value.
        wait_tick(0, 20, n);
        repeat (3) step();
        write(0, 2);
        en[0] = 1'b0;
        step();
        chk("dis out", {31'd0, out_a[0]}, 0);
        chk("dis pend", {31'd0, pend_a[0]}, 0);
        en[0] = 1'b1;
        wait_tick(0, 20, n); chk("dis reenable", n, 3);

        // Random traffic, checked cycle by cycle.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0)
                write($urandom_range(0, 3), $urandom_range(0, 12));
            else begin
                if ($urandom_range(0, 39) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
`ifdef PROG_CLK_DIV_SYNC_EN
                sync_all = ($urandom_range(0, 99) == 0);
`endif
                step();
                sync_all = 1'b0;
            end
        end

        // Reset mid-period, with a write pending.
        en = 4'b1111;
        write(1, 9);
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("async out", {28'd0, out_a}, 0);
        chk("async tick", {28'd0, tick_a}, 0);
        chk("async pend", {28'd0, pend_a}, 0);
        repeat (2) step();
        en = 4'b0001;
        reset = 1'b1;
        wait_tick(0, 20, n); chk("post-rst half", n, 5);

`ifdef PROG_CLK_DIV_SYNC_EN
        begin
            int r0, r1;
            en = 4'b0000;
            write(0, 2);
            write(1, 5);
            step();
            en = 4'b0011;
            repeat (7) step();
            sync_all = 1'b1;
            step();
            sync_all = 1'b0;
            chk("sync out low", {30'd0, out_a[1:0]}, 0);
            r0 = 0; r1 = 0;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (r0 == 0 && out_a[0]) r0 = k;
                if (r1 == 0 && out_a[1]) r1 = k;
            end
            chk("sync rise D2", r0, 3);
            chk("sync rise D5", r1, 6);
        end
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
